replay_buffer_ctrl: RTL

// - Sequencer for the ping-pong spike replay buffer in the multiplexed column.
// - Each gamma cycle it writes spikes into one bank, replays the other bank and swaps banks at the grst boundary.
// - Replay covers NUM_INPUTS input groups: one pass per group, every NUM_INPUTS-th slot read.
// - Drives buf_sel, wr_idx, rd_idx and mux_sel of the buffer, plus valid/status to the column.

---
 rtl/replay_buffer_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/replay_buffer_ctrl.sv
// Ping-pong spike replay buffer sequencer: one bank is written while the other is replayed group by group.
// Optional statistics outputs (gamma_cnt, err_cnt) are built when REPLAY_CTRL_STATS_EN is defined.
module replay_buffer_ctrl #(
  parameter int BUFFER_DEPTH = 16,
  parameter int NUM_INPUTS   = 2,
  parameter int STAT_W       = 16,
  localparam int IW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1,
  localparam int MW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grst,
  input  logic              en,
  output logic              buf_sel,
  output logic [IW-1:0]     wr_idx,
  output logic              wr_en,
  output logic [IW-1:0]     rd_idx,
  output logic [MW-1:0]     mux_sel,
  output logic              rd_valid,
  output logic              replay_done,
  output logic              replay_abort,
`ifdef REPLAY_CTRL_STATS_EN
  output logic              overflow,
  output logic [STAT_W-1:0] gamma_cnt,
  output logic [STAT_W-1:0] err_cnt
`else
  output logic              overflow
`endif
);

  localparam int GROUP_LEN = BUFFER_DEPTH / NUM_INPUTS;
  localparam int KW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(GROUP_LEN - 1);
  localparam logic [MW-1:0] P_LAST = MW'(NUM_INPUTS - 1);
  localparam logic [IW-1:0] W_LAST = IW'(BUFFER_DEPTH - 1);
  localparam logic [IW-1:0] STRIDE = IW'(NUM_INPUTS);

  if ((BUFFER_DEPTH % NUM_INPUTS) != 0 || STAT_W < 1) begin : g_bad_config
    $error("replay_buffer_ctrl: BUFFER_DEPTH must be a multiple of NUM_INPUTS and STAT_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t        state, state_next;
  logic          grst_q;
  logic          grst_edge;
  logic [KW-1:0] k, k_next;
  logic [MW-1:0] p, p_next;
  logic          buf_sel_next, wr_en_next, rd_valid_next;
  logic [IW-1:0] wr_idx_next;
  logic          done_next, abort_next, overflow_next;
  logic          last_sample;

  assign grst_edge   = grst & ~grst_q;
  assign last_sample = rd_valid && (k == K_LAST) && (p == P_LAST);
  assign rd_idx      = IW'(k) * STRIDE;
  assign mux_sel     = p;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grst_q       <= 1'b0;
      buf_sel      <= 1'b0;
      wr_idx       <= '0;
      wr_en        <= 1'b0;
      k            <= '0;
      p            <= '0;
      rd_valid     <= 1'b0;
      replay_done  <= 1'b0;
      replay_abort <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      grst_q       <= grst;
      buf_sel      <= buf_sel_next;
      wr_idx       <= wr_idx_next;
      wr_en        <= wr_en_next;
      k            <= k_next;
      p            <= p_next;
      rd_valid     <= rd_valid_next;
      replay_done  <= done_next;
      replay_abort <= abort_next;
      overflow     <= overflow_next;
    end
  end

  // A boundary restarts both write and replay; a replay cut short only aborts if its final sample was not yet reached.
  always_comb begin
    state_next    = state;
    buf_sel_next  = buf_sel;
    wr_idx_next   = wr_idx;
    wr_en_next    = wr_en;
    k_next        = k;
    p_next        = p;
    rd_valid_next = rd_valid;
    done_next     = 1'b0;
    abort_next    = 1'b0;
    overflow_next = 1'b0;

    if (grst_edge && (en || state != IDLE)) begin
      k_next      = '0;
      p_next      = '0;
      wr_idx_next = '0;
      if (en) begin
        state_next    = (state == IDLE) ? FILL : RUN;
        buf_sel_next  = ~buf_sel;
        wr_en_next    = 1'b1;
        rd_valid_next = (state != IDLE);
        done_next     = last_sample;
        abort_next    = rd_valid && !last_sample;
      end else begin
        state_next    = IDLE;
        wr_en_next    = 1'b0;
        rd_valid_next = 1'b0;
      end
    end else if (!grst_edge) begin
      if (wr_en) begin
        if (wr_idx == W_LAST) begin
          wr_en_next    = 1'b0;
          overflow_next = 1'b1;
        end else begin
          wr_idx_next = wr_idx + IW'(1);
        end
      end
      if (rd_valid) begin
        if (k == K_LAST) begin
          k_next = '0;
          if (p == P_LAST) begin
            p_next        = '0;
            rd_valid_next = 1'b0;
            done_next     = 1'b1;
          end else begin
            p_next = p + MW'(1);
          end
        end else begin
          k_next = k + KW'(1);
        end
      end
    end
  end

`ifdef REPLAY_CTRL_STATS_EN
  // Saturating counters; a boundary counts when it leads into FILL or RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      gamma_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (grst_edge && en && !(&gamma_cnt)) gamma_cnt <= gamma_cnt + STAT_W'(1);
      if ((overflow_next || abort_next) && !(&err_cnt)) err_cnt <= err_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
